counter_stream_checker: RTL and testbench
=========================================

# counter_stream_checker

Receive-side checker for the free-running 8-bit incrementing counter stream the team's counter tiles drive on their output pins. It samples an 8-bit data bus, acquires lock onto the +1 sequence, and then flywheels alongside it. Each break in the sequence is flagged and counted. It sits on the input side of a test tile, for example on `ui_in` of a loopback board, and its status drives that tile's outputs.

## Interface
- `WIDTH`, default 8: data bus width; the sequence wraps modulo 2^WIDTH.
- `LOCK_COUNT`, default 4: consecutive correct samples required to declare lock (≥1).
- `LOSS_COUNT`, default 3: consecutive mismatches while locked before lock is dropped (≥1).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  WIDTH: counter value under test.
- `din_valid`  in  1: `din` is sampled only on cycles where this is high.
- `clear`  in  1: synchronous clear of `err_count` (and of the capture registers, if compiled in).
- `locked`  out  1: checker is in LOCKED.
- `err_pulse`  out  1: one-cycle flag for a mismatch while locked.
- `err_count`  out  8: saturating mismatch count.
- `state`  out  2: current FSM state, for debug.

## Operation
- FSM states: HUNT=0, ACQUIRE=1, LOCKED=2. Encoding 3 is illegal and returns to HUNT on the next clock.
- Internal registers:
  - `expected` (WIDTH bits).
  - `match_cnt`, sized to hold `LOCK_COUNT`.
  - `miss_cnt`, sized to hold `LOSS_COUNT`.
- When `din_valid` is low, no register changes, except that `clear` still acts.
- HUNT, on a valid sample: load `expected` = `din`+1, set `match_cnt`=0, go to ACQUIRE.
- ACQUIRE, on a valid sample:
  - `din`==`expected`: increment `match_cnt` and `expected`. If the new `match_cnt` equals `LOCK_COUNT`, go to LOCKED with `miss_cnt`=0.
  - Mismatch: reload `expected` = `din`+1, set `match_cnt`=0, stay in ACQUIRE. No error is flagged.
- LOCKED, on a valid sample:
  - `expected` always increments (flywheel), whether or not the sample matched.
  - Match: `miss_cnt`=0.
  - Mismatch: `err_pulse`=1, `err_count` increments (saturating), `miss_cnt` increments.
  - When the new `miss_cnt` equals `LOSS_COUNT`, go to HUNT.
- Arithmetic is modulo 2^WIDTH. A wrap from all-ones to zero counts as a match.
- `err_count` saturates at 255 and never wraps.
- `clear` and a mismatch in the same cycle: `clear` wins and `err_count` becomes 0. `err_pulse` still asserts.
- `clear` does not change the FSM state or `expected`.
- Reset in any state, including mid-acquire: the FSM goes to HUNT and all counters and outputs go to 0.

## Timing
- All outputs are registered.
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, `state`=0.
- Lock latency: `locked` rises on the clock edge that samples the `LOCK_COUNT`-th consecutive matching `din` after the HUNT load sample. That is `LOCK_COUNT`+1 valid samples from HUNT.
- `err_pulse` and `err_count` update on the same edge that samples the bad `din`, so they are visible in the following cycle.
- `locked` falls on the edge that samples the `LOSS_COUNT`-th consecutive miss. That miss also pulses `err_pulse`.

## Configuration
- Macro: `CNT_CHK_CAPTURE_EN`.
- When defined, two extra outputs are added:
  - `first_bad` (WIDTH): `din` of the first mismatch seen while locked since reset or `clear`.
  - `first_exp` (WIDTH): the matching `expected` value for that mismatch.
  - Both hold their value until `rst` or `clear`; both reset to 0.
- When undefined, these ports and registers do not exist.

## Structure
- Shared package `cnt_chk_pkg` holds:
  - the state enum: HUNT, ACQUIRE, LOCKED;
  - the constant `ERR_CNT_W`=8;
  - the default values of `LOCK_COUNT` and `LOSS_COUNT`.
- One sub-module, `sat_counter`: a parameterised-width saturating incrementer with clear. It is used for `err_count` and is reusable by other tiles.
- Everything else lives in a single file.

## Test plan
- Clean stream: reset, then `din`=0,1,2,… every cycle. Expect `locked`=1 after 5 valid samples, and `err_count` stays 0 through the 0xFF→0x00 wrap.
- Single glitch while locked: stream 10..20, with `din`=0x55 substituted for 15. Expect one `err_pulse`, `err_count`=1, `locked` held, and `miss_cnt` recovering because 16 matches.
- Loss of lock: while locked, drive `din`=0 for 3 valid cycles. Expect three `err_pulse`s, `err_count`=3, and `state`=HUNT after the third.
- Gapped valid: toggle `din_valid` 1/0 with `din` incrementing only on valid cycles. Expect lock after 5 valid samples and no errors.
- Saturation and clear: force 300 mismatches with repeated relock. Expect `err_count`=255. Then assert `clear` together with a mismatch: expect `err_count`=0 and `err_pulse`=1.
- Reset mid-acquire: assert `rst` after 2 matches. Expect `state`=0, `locked`=0, and a full 5-sample reacquire afterwards.

Source files
------------

// File: rtl/cnt_chk_pkg.sv
// Shared types and constants for the counter stream checker and related tiles.

package cnt_chk_pkg;

    localparam int ERR_CNT_W      = 8;
    localparam int LOCK_COUNT_DEF = 4;
    localparam int LOSS_COUNT_DEF = 3;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } chk_state_e;

endpackage

// File: rtl/counter_stream_checker_sat_counter.sv
// sat_counter: parameterised-width saturating incrementer with synchronous clear.
// Clear has priority over increment; the count sticks at all-ones.

module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_stream_checker.sv
// Receive-side checker for an incrementing counter stream: acquires lock, flywheels, counts breaks.
// Optional capture of the first locked mismatch is compiled in with CNT_CHK_CAPTURE_EN.

module counter_stream_checker
    import cnt_chk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int LOSS_COUNT = LOSS_COUNT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
`ifdef CNT_CHK_CAPTURE_EN
    output logic [WIDTH-1:0]     first_bad,
    output logic [WIDTH-1:0]     first_exp,
`endif
    output logic [1:0]           state
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]  LOSS_TGT = MISS_W'(LOSS_COUNT);

    chk_state_e         state_q, state_d;
    logic [WIDTH-1:0]   expected_q, expected_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;

    logic               hit;
    logic [WIDTH-1:0]   din_inc;
    logic [WIDTH-1:0]   exp_inc;
    logic [MATCH_W-1:0] match_nxt;
    logic [MISS_W-1:0]  miss_nxt;

    assign hit       = (din == expected_q);
    assign din_inc   = din + WIDTH'(1);
    assign exp_inc   = expected_q + WIDTH'(1);
    assign match_nxt = match_cnt_q + MATCH_W'(1);
    assign miss_nxt  = miss_cnt_q + MISS_W'(1);

    // NOTE: every variable gets a hold value before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        case (state_q)
            HUNT: begin
                if (din_valid) begin
                    expected_d  = din_inc;
                    match_cnt_d = '0;
                    state_d     = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (din_valid) begin
                    if (hit) begin
                        expected_d  = exp_inc;
                        match_cnt_d = match_nxt;
                        if (match_nxt == LOCK_TGT) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        expected_d  = din_inc;
                        match_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (din_valid) begin
                    // Flywheel: the local count advances regardless of what arrived.
                    expected_d = exp_inc;
                    if (hit) begin
                        miss_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_nxt;
                        if (miss_nxt == LOSS_TGT) begin
                            state_d = HUNT;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        locked_d    = (state_d == LOCKED);
        err_pulse_d = din_valid && (state_q == LOCKED) && !hit;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (err_pulse_d),
        .count (err_count)
    );

`ifdef CNT_CHK_CAPTURE_EN
    logic             first_seen_q, first_seen_d;
    logic [WIDTH-1:0] first_bad_q, first_bad_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d;

    always_comb begin
        first_seen_d = first_seen_q;
        first_bad_d  = first_bad_q;
        first_exp_d  = first_exp_q;
        if (clear) begin
            first_seen_d = 1'b0;
            first_bad_d  = '0;
            first_exp_d  = '0;
        end else if (err_pulse_d && !first_seen_q) begin
            first_seen_d = 1'b1;
            first_bad_d  = din;
            first_exp_d  = expected_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_seen_q <= 1'b0;
            first_bad_q  <= '0;
            first_exp_q  <= '0;
        end else begin
            first_seen_q <= first_seen_d;
            first_bad_q  <= first_bad_d;
            first_exp_q  <= first_exp_d;
        end
    end

    assign first_bad = first_bad_q;
    assign first_exp = first_exp_q;
`endif

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign state     = state_q;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Self-checking bench for counter_stream_checker: directed scenarios plus randomized stream
// against a run-length reference model. Capture outputs are checked when CNT_CHK_CAPTURE_EN is set.

module tb_counter_stream_checker;

    localparam int W    = 8;
    localparam int LOCK = 4;
    localparam int LOSS = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         clear;
    logic         locked;
    logic         err_pulse;
    logic [7:0]   err_count;
    logic [1:0]   state;
`ifdef CNT_CHK_CAPTURE_EN
    logic [W-1:0] first_bad;
    logic [W-1:0] first_exp;
`endif

    counter_stream_checker #(
        .WIDTH      (W),
        .LOCK_COUNT (LOCK),
        .LOSS_COUNT (LOSS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
`ifdef CNT_CHK_CAPTURE_EN
        .first_bad (first_bad),
        .first_exp (first_exp),
`endif
        .state     (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: before lock, track the length of the current +1 run starting at
    // the first sample after hunting; lock once the run is LOCK+1 samples long.
    int m_run, m_last, m_fly, m_miss, m_errs;
    bit m_locked, m_pulse, m_seen;
    int m_fbad, m_fexp;

    task automatic model_reset();
        m_run = 0; m_last = 0; m_fly = 0; m_miss = 0; m_errs = 0;
        m_locked = 0; m_pulse = 0; m_seen = 0; m_fbad = 0; m_fexp = 0;
    endtask

    task automatic model_step(input int d, input bit v, input bit c);
        m_pulse = 0;
        if (v) begin
            if (m_locked) begin
                if (d != m_fly) begin
                    m_pulse = 1;
                    if (m_errs < 255) m_errs++;
                    if (!m_seen) begin
                        m_seen = 1; m_fbad = d; m_fexp = m_fly;
                    end
                    m_miss++;
                    if (m_miss == LOSS) begin
                        m_locked = 0;
                        m_run    = 0;
                    end
                end else begin
                    m_miss = 0;
                end
                m_fly = (m_fly + 1) % 256;
            end else begin
                if (m_run != 0 && d == (m_last + 1) % 256) m_run++;
                else m_run = 1;
                m_last = d;
                if (m_run == LOCK + 1) begin
                    m_locked = 1;
                    m_miss   = 0;
                    m_fly    = (d + 1) % 256;
                end
            end
        end
        if (c) begin
            m_errs = 0; m_seen = 0; m_fbad = 0; m_fexp = 0;
        end
    endtask

    task automatic compare_all();
        int exp_state;
        exp_state = m_locked ? 2 : ((m_run == 0) ? 0 : 1);
        check("locked", 32'(locked), 32'(m_locked));
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("err_count", 32'(err_count), 32'(m_errs));
        check("state", 32'(state), 32'(exp_state));
`ifdef CNT_CHK_CAPTURE_EN
        check("first_bad", 32'(first_bad), 32'(m_fbad));
        check("first_exp", 32'(first_exp), 32'(m_fexp));
`endif
    endtask

    task automatic step(input int d, input bit v, input bit c);
        @(negedge clk);
        rst       = 1'b0;
        din       = W'(d);
        din_valid = v;
        clear     = c;
        @(posedge clk);
        model_step(d % 256, v, c);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int cycles, input bit v);
        @(negedge clk);
        rst       = 1'b1;
        din_valid = v;
        clear     = 1'b0;
        din       = W'($urandom);
        repeat (cycles) @(posedge clk);
        model_reset();
        #1;
        compare_all();
    endtask

    int cnt;
    int base;

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; clear = 1'b0;

        // Clean stream through the wrap
        do_reset(2, 1'b0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        for (int i = 0; i < 300; i++) begin
            step(i, 1'b1, 1'b0);
            if (i == 3) check("pre_lock_4", 32'(locked), 32'd0);
            if (i == 4) check("lock_at_5", 32'(locked), 32'd1);
        end
        check("wrap_no_errs", 32'(err_count), 32'd0);
        check("wrap_locked", 32'(locked), 32'd1);

        // Single glitch while locked
        do_reset(1, 1'b1);
        for (int v = 10; v <= 20; v++) begin
            step((v == 15) ? 'h55 : v, 1'b1, 1'b0);
            if (v == 15) check("glitch_pulse", 32'(err_pulse), 32'd1);
            if (v == 16) check("glitch_recover", 32'(err_pulse), 32'd0);
        end
        check("glitch_count", 32'(err_count), 32'd1);
        check("glitch_locked", 32'(locked), 32'd1);

        // Loss of lock after three consecutive misses
        step(21, 1'b1, 1'b1);
        check("clear_on_match", 32'(err_count), 32'd0);
        step(22, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1'b1, 1'b0);
            check("loss_pulse", 32'(err_pulse), 32'd1);
            if (k < 2) check("loss_held", 32'(locked), 32'd1);
        end
        check("loss_count", 32'(err_count), 32'd3);
        check("loss_state_hunt", 32'(state), 32'd0);
        check("loss_unlocked", 32'(locked), 32'd0);

        // Gapped valid
        do_reset(1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(100 + i, 1'b1, 1'b0);
            if (i == 3) check("gap_pre_lock", 32'(locked), 32'd0);
            if (i == 4) check("gap_lock", 32'(locked), 32'd1);
            step($urandom_range(0, 255), 1'b0, 1'b0);
        end
        check("gap_no_errs", 32'(err_count), 32'd0);

        // Saturation via repeated relock, then clear colliding with a mismatch
        do_reset(1, 1'b0);
        base = 0;
        for (int r = 0; r < 100; r++) begin
            for (int i = 0; i < 5; i++) step(base + i, 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) step(base + 5 + i + 128, 1'b1, 1'b0);
            base = (base + 37) % 256;
        end
        check("sat_255", 32'(err_count), 32'd255);
        for (int i = 0; i < 5; i++) step(base + i, 1'b1, 1'b0);
        check("sat_relock", 32'(locked), 32'd1);
        step(base + 5 + 128, 1'b1, 1'b1);
        check("clear_wins", 32'(err_count), 32'd0);
        check("clear_pulse", 32'(err_pulse), 32'd1);

        // Reset mid-acquire
        do_reset(1, 1'b0);
        step(40, 1'b1, 1'b0);
        step(41, 1'b1, 1'b0);
        step(42, 1'b1, 1'b0);
        check("mid_acq_state", 32'(state), 32'd1);
        do_reset(1, 1'b1);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(43 + i, 1'b1, 1'b0);
            if (i == 3) check("reacq_pre_lock", 32'(locked), 32'd0);
        end
        check("reacq_lock", 32'(locked), 32'd1);

        // Randomized stream with glitches, gaps, clears and occasional resets
        cnt = $urandom_range(0, 255);
        for (int n = 0; n < 4000; n++) begin
            bit v;
            bit c;
            int d;
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1, 1'b1);
                continue;
            end
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 255);
            else d = cnt;
            if ($urandom_range(0, 99) == 0) cnt = $urandom_range(0, 255);
            step(d, v, c);
            if (v) cnt = (cnt + 1) % 256;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
